// File: rtl/div_ctrl.sv
// Iterative restoring divide sequencer for the execute stage.
// Produces one quotient bit per cycle and stalls F/D/E while a divide is in flight.
module div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_startE,
  input  logic             div_signedE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             annulM,
  output logic             stall_divE,
  output logic             div_doneE,
  output logic [WIDTH-1:0] hi_divE,
  output logic [WIDTH-1:0] lo_divE
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [5:0] LAST_ITER = 6'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH+1:0] rem_sh, trial;
  logic [WIDTH:0]   rem_nx;
  logic [WIDTH-1:0] quo_nx;

  always_comb begin
    mag_a = (div_signedE & srcaE[WIDTH-1]) ? -srcaE : srcaE;
    mag_b = (div_signedE & srcbE[WIDTH-1]) ? -srcbE : srcbE;

    // One restoring step; bit WIDTH+1 of the trial is the borrow.
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    trial  = rem_sh - {2'b00, dvs_q};
    if (!trial[WIDTH+1]) begin
      rem_nx = trial[WIDTH:0];
      quo_nx = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_nx = rem_sh[WIDTH:0];
      quo_nx = {quo_q[WIDTH-2:0], 1'b0};
    end

    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (div_startE) begin
          neg_q_d = div_signedE & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
          neg_r_d = div_signedE & srcaE[WIDTH-1];
          dvs_d   = mag_b;
          quo_d   = mag_a;
          rem_d   = '0;
          cnt_d   = '0;
          if (srcbE == '0) begin
            lo_d    = '1;
            hi_d    = srcaE;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LAST_ITER) begin
          lo_d    = neg_q_q ? -quo_nx : quo_nx;
          hi_d    = neg_r_q ? -rem_nx[WIDTH-1:0] : rem_nx[WIDTH-1:0];
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A flush wins over everything, including a completion in the same cycle.
    if (annulM) begin
      state_d = IDLE;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      done_q  <= done_d;
    end
  end

  assign stall_divE = !annulM & (((state_q == IDLE) & div_startE) | (state_q == BUSY));
  assign div_doneE  = done_q;
  assign hi_divE    = hi_q;
  assign lo_divE    = lo_q;

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Iterative divide sequencer for the MIPS pipeline's execute stage. It accepts DIV/DIVU operands from E and runs a 32-iteration restoring divider, one quotient bit per cycle. While busy it drives `stall_divE` into the hazard unit, so F/D/E hold and the divide instruction stays in E until the result is ready. An exception flush from M cancels an in-flight divide without producing a result.

## Interface
Parameters:
- `WIDTH`, 32: operand and result width. Only 32 is supported; the iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  system clock; everything is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `div_startE`  in  1  E stage holds a valid DIV/DIVU. Stays high while E is stalled.
- `div_signedE`  in  1  1 = DIV (signed), 0 = DIVU.
- `srcaE`  in  32  dividend (forwarded rs value).
- `srcbE`  in  32  divisor (forwarded rt value).
- `annulM`  in  1  exception flush (`except_typeM != 0`). Cancels any divide.
- `stall_divE`  out  1  combinational stall request to the hazard unit.
- `div_doneE`  out  1  registered, one-cycle pulse: `hi_divE`/`lo_divE` are valid.
- `hi_divE`  out  32  remainder.
- `lo_divE`  out  32  quotient.

## Operation
States: IDLE, BUSY, DONE.

IDLE
- If `div_startE & !annulM`, latch:
  - magnitudes of both operands (two's-complement absolute value when signed),
  - `neg_q = signed & (a[31] ^ b[31])`,
  - `neg_r = signed & a[31]`.
- Clear the 6-bit iteration counter and the 33-bit partial remainder.
- Divisor == 0: go to DONE directly with `lo = 32'hFFFFFFFF`, `hi = srcaE` (raw dividend). This result is defined by the team.
- Otherwise go to BUSY.

BUSY
- Each cycle:
  - shift `{rem, quo}` left by 1, shifting in the next dividend bit from the MSB,
  - trial-subtract the divisor from `rem[32:0]`,
  - if the result is non-negative, keep it and set the quotient LSB; otherwise restore.
- After 32 iterations (counter reaches 31), go to DONE.
- When entering DONE, apply sign fixup and register the results:
  - `lo = neg_q ? -quo : quo`,
  - `hi = neg_r ? -rem : rem`.

DONE
- `div_doneE` is 1 for exactly this cycle and `stall_divE` is 0, so the pipeline advances.
- Next state is IDLE unconditionally. This rule prevents the same instruction from being re-accepted.

Stall rule
- `stall_divE = !annulM & ((state==IDLE & div_startE) | state==BUSY)`.

Annul
- `annulM` high in any state: next state is IDLE, no `div_doneE` pulse, and `hi_divE`/`lo_divE` keep their previous values.
- `annulM` takes priority over a DONE transition in the same cycle.

Outputs
- `hi_divE`/`lo_divE` change only on entry to DONE and hold until the next completed divide.

## Timing
- Reset values: state IDLE, counter 0, `stall_divE` 0, `div_doneE` 0, `hi_divE` 0, `lo_divE` 0.
- Reset mid-operation aborts immediately, with the same values as above, one edge after `rst` is sampled high.
- Normal divide, with cycle 0 being the first cycle `div_startE` is seen in IDLE:
  - `stall_divE` is high in cycles 0..32 (33 cycles),
  - DONE occurs in cycle 33 with `div_doneE` = 1 and `stall_divE` = 0,
  - the instruction leaves E at the end of cycle 33.
- Divide by zero: `stall_divE` is high in cycle 0 only; DONE occurs in cycle 1.
- Back-to-back divides: a new `div_startE` can be accepted in the IDLE cycle right after DONE, giving a minimum spacing of 34 cycles.
- `annulM` is combinational into `stall_divE`. The flush cycle never stalls, so the hazard unit can flush E in that same cycle.
- Arithmetic:
  - the partial remainder is 33 bits wide so the trial subtract's borrow is visible,
  - the magnitude of `32'h80000000` is `32'h80000000` (unsigned view); this gives the correct result for the most-negative dividend,
  - `0x80000000 / -1` (signed) yields `lo = 32'h80000000`, `hi = 0`, with no trap.

## Test plan
- DIVU 100 / 7 → `stall_divE` high for 33 cycles; cycle 33: `div_doneE` = 1, `lo_divE = 14`, `hi_divE = 2`; `div_doneE` low in cycle 34.
- DIV -7 / 2 (`FFFFFFF9`, `2`) → `lo_divE = FFFFFFFD`, `hi_divE = FFFFFFFF`.
- DIV 7 / -2 (`7`, `FFFFFFFE`) → `lo_divE = FFFFFFFD`, `hi_divE = 1`.
- DIV `80000000` / `FFFFFFFF` → `lo_divE = 80000000`, `hi_divE = 0`.
- DIVU 5 / 0 → stall for 1 cycle; cycle 1: `div_doneE` = 1, `lo_divE = FFFFFFFF`, `hi_divE = 5`.
- Annul: start DIVU 100 / 7, assert `annulM` in BUSY cycle 10 → `stall_divE` = 0 in that cycle, state IDLE next cycle, no `div_doneE` pulse, `hi_divE`/`lo_divE` unchanged from the prior result.
- Two DIVUs back-to-back (100 / 7, then 9 / 3) → two `div_doneE` pulses 34 cycles apart; second result `lo_divE = 3`, `hi_divE = 0`.
- Assert `rst` in BUSY cycle 5 → all outputs 0 after that edge; a following divide completes normally.
